seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle N-bit integer divider; the inverse arithmetic path to the team's adder blocks.
- Computes quotient and remainder one bit per clock using restoring division.
- Each step is a trial subtract on an (N+1)-bit partial remainder.
- Sits beside the ALU adders. It is driven by a start/done handshake from the execute-stage controller.

Parameters:
N, 32, operand, quotient and remainder width in bits (N >= 2)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; A and B are sampled on the same edge
A  input  N  dividend
B  input  N  divisor
Q  output  N  quotient; held stable from done until the next accepted start
R  output  N  remainder; held stable from done until the next accepted start
busy  output  1  high while an iteration is in progress
done  output  1  one-cycle pulse when Q and R are valid
dbz  output  1  divide-by-zero flag; valid with done, held with Q and R
OF  output  1  overflow flag; valid with done (always 0 unless the optional feature is compiled in)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset:
  - Takes effect immediately, including mid-operation; no partial result survives.
  - State goes to IDLE.
  - Q=0, R=0, busy=0, done=0, dbz=0, OF=0.
  - Internal remainder, divisor and counter registers are cleared.
- States and transitions:
  - IDLE: start=1 latches A and B.
    - If B==0, go to DONE.
    - Otherwise clear the partial remainder, load the dividend shift register with A, load the counter with N-1, and go to RUN.
  - RUN: each cycle, shift {rem, dvd} left by 1 and compute trial = rem - {1'b0,B} at N+1 bits.
    - If trial is non-negative: rem = trial and the new quotient bit is 1; otherwise rem is unchanged and the bit is 0.
    - When counter==0, go to DONE; otherwise decrement the counter.
    - start is ignored in RUN; operands are not re-sampled.
  - DONE: done=1 for exactly one cycle, with Q, R, dbz and OF updated on entry.
    - The next state is IDLE.
    - start=1 while in DONE is accepted exactly as in IDLE, giving back-to-back operation with no bubble.
- Latency (start sampled at edge k):
  - Normal operation: busy=1 for edges k+1 .. k+N; done=1 in the cycle after edge k+N+1.
  - Divide by zero: busy stays 0; done=1 in the cycle after edge k+1.
  - Total latency is fixed and data independent: N+1 cycles normal, 1 cycle for divide by zero.
- Divide by zero: Q = all ones, R = A, dbz=1.
- Arithmetic:
  - Unsigned; Q = floor(A/B), R = A - Q*B, with R < B guaranteed.
  - The partial remainder is N+1 bits so the trial subtract never loses the borrow.
- Clearing rules:
  - dbz and OF clear only on the next accepted start or on reset.
  - done deasserts automatically after its one cycle.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined:
  - A and B are two's complement.
  - Operands are converted to magnitudes at accept time, and the unsigned core runs unchanged.
  - On entering DONE, Q is negated if sign(A) != sign(B), and R is negated if A is negative (truncating division; R takes the sign of A).
  - A = most-negative value with B = -1 gives Q = most-negative value, R = 0, OF=1.
  - Divide by zero gives Q = all ones, R = A, dbz=1.
  - Latency is unchanged; the sign fix-up happens in the DONE-entry register write.
- Undefined: unsigned only; OF is tied to 0.

Test Plan:
1. N=32, A=100, B=7, start 1 cycle -> busy high 32 cycles; done at cycle 33; Q=14, R=2, dbz=0.
2. A=5, B=9 -> Q=0, R=5. Then A=0xFFFFFFFF, B=1 issued in the done cycle -> accepted back-to-back; Q=0xFFFFFFFF, R=0.
3. A=0x1234, B=0 -> done at cycle 1, busy never high; Q=0xFFFFFFFF, R=0x1234, dbz=1. The next valid op clears dbz.
4. A=1000, B=3 started, then start with A=50, B=5 pulsed mid-RUN -> second request ignored; Q=333, R=1.
5. Start A=1000, B=3, assert rst at cycle 10 -> all outputs 0 immediately, state IDLE. A fresh A=9, B=2 then gives Q=4, R=1.
6. SIGNED_DIV_EN: A=-7, B=2 -> Q=-3, R=-1. A=0x80000000, B=-1 -> Q=0x80000000, R=0, OF=1.

Source files
------------

// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// master: execute-stage controller (drives start/A/B).
// slave : the divider (drives results and status).
interface seq_divider_if #(
   parameter int N = 32
);
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [N-1:0] Q;
   logic [N-1:0] R;
   logic         busy;
   logic         done;
   logic         dbz;
   logic         OF;

   modport master (output start, A, B, input Q, R, busy, done, dbz, OF);
   modport slave  (input start, A, B, output Q, R, busy, done, dbz, OF);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// The unsigned core always runs on magnitudes. Define SIGNED_DIV_EN to
// accept two's complement operands: the sign fix-up is folded into the
// result write, so latency does not change.
// The default build is unsigned only, and OF stays 0.
module seq_divider #(
   parameter int N = 32
) (
   input  logic          clk,
   input  logic          rst,
   seq_divider_if.slave  dif
);
   localparam int CW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_nxt;
   logic           accept;

   logic [N-1:0]   rem;      // partial remainder, always < divisor
   logic [N-1:0]   dvd;      // dividend shifting out, quotient shifting in
   logic [N-1:0]   dvs;      // latched divisor magnitude
   logic [CW-1:0]  cnt;
   logic [N-1:0]   q_r, r_r;
   logic           dbz_r, of_r;

   logic [N-1:0]   ua, ub;   // operand magnitudes at accept time
   logic           ovf_in;
   logic           q_neg_r, r_neg_r, ovf_r;

   logic [N:0]     sh, trial;
   logic [N-1:0]   rem_step, dvd_step;
   logic [N-1:0]   q_fin, r_fin;

`ifdef SIGNED_DIV_EN
   logic a_neg, b_neg;
   assign a_neg  = dif.A[N-1];
   assign b_neg  = dif.B[N-1];
   assign ua     = a_neg ? (~dif.A + 1'b1) : dif.A;
   assign ub     = b_neg ? (~dif.B + 1'b1) : dif.B;
   assign ovf_in = (dif.A == {1'b1, {(N-1){1'b0}}}) && (dif.B == {N{1'b1}});
`else
   assign ua     = dif.A;
   assign ub     = dif.B;
   assign ovf_in = 1'b0;
`endif

   // One restoring step. sh is the (N+1)-bit partial remainder, so the
   // trial subtract keeps its borrow in bit N.
   always_comb begin
      sh       = {rem, dvd[N-1]};
      trial    = sh - {1'b0, dvs};
      rem_step = trial[N] ? sh[N-1:0] : trial[N-1:0];
      dvd_step = {dvd[N-2:0], ~trial[N]};
      q_fin    = q_neg_r ? (~dvd_step + 1'b1) : dvd_step;
      r_fin    = r_neg_r ? (~rem_step + 1'b1) : rem_step;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state. DONE accepts a new start like IDLE, so there is no bubble.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (state == DONE) state_nxt = IDLE;
            if (dif.start) begin
               accept    = 1'b1;
               state_nxt = (dif.B == '0) ? DONE : RUN;
            end
         end
         RUN: if (cnt == '0) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: load on accept, iterate in RUN, write results on DONE entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem     <= '0;
         dvd     <= '0;
         dvs     <= '0;
         cnt     <= '0;
         q_r     <= '0;
         r_r     <= '0;
         dbz_r   <= 1'b0;
         of_r    <= 1'b0;
         q_neg_r <= 1'b0;
         r_neg_r <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (accept) begin
         dbz_r <= 1'b0;
         of_r  <= 1'b0;
         dvs   <= ub;
         if (dif.B == '0) begin
            q_r   <= '1;
            r_r   <= dif.A;
            dbz_r <= 1'b1;
         end else begin
            rem   <= '0;
            dvd   <= ua;
            cnt   <= CW'(N-1);
            ovf_r <= ovf_in;
`ifdef SIGNED_DIV_EN
            q_neg_r <= a_neg ^ b_neg;
            r_neg_r <= a_neg;
`else
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
`endif
         end
      end else if (state == RUN) begin
         rem <= rem_step;
         dvd <= dvd_step;
         if (cnt == '0) begin
            q_r  <= q_fin;
            r_r  <= r_fin;
            of_r <= ovf_r;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign dif.Q    = q_r;
   assign dif.R    = r_r;
   assign dif.busy = (state == RUN);
   assign dif.done = (state == DONE);
   assign dif.dbz  = dbz_r;
   assign dif.OF   = of_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=32), hand-computed expectations.
module tb_seq_divider;
   localparam int N = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   lat, bcnt;

   seq_divider_if #(.N(N)) dif ();

   seq_divider #(.N(N)) u_dut (
      .clk (clk),
      .rst (rst),
      .dif (dif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Drive a one-cycle start; returns #1 after the accepting edge.
   task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
      dif.start = 1'b1;
      dif.A     = a;
      dif.B     = b;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
   endtask

   // Cycles from the accepting edge until done is seen, plus busy samples.
   task automatic wait_done(output int l, output int bc);
      l  = 0;
      bc = 0;
      while (!dif.done && l < 100) begin
         bc += int'(dif.busy);
         @(posedge clk);
         #1;
         l++;
      end
      if (!dif.done) chk("timeout", 64'd0, 64'd1);
   endtask

   initial begin
      dif.start = 1'b0;
      dif.A     = '0;
      dif.B     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_Q",    dif.Q,    0);
      chk("rst_R",    dif.R,    0);
      chk("rst_busy", dif.busy, 0);
      chk("rst_done", dif.done, 0);
      chk("rst_dbz",  dif.dbz,  0);
      chk("rst_OF",   dif.OF,   0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: basic 100/7
      start_op(32'd100, 32'd7);
      wait_done(lat, bcnt);
      chk("t1_lat",  lat + 1, 33);
      chk("t1_busy", bcnt, 32);
      chk("t1_Q",    dif.Q, 14);
      chk("t1_R",    dif.R, 2);
      chk("t1_dbz",  dif.dbz, 0);
      chk("t1_OF",   dif.OF, 0);
      @(posedge clk);
      #1;
      chk("t1_done_pulse", dif.done, 0);
      chk("t1_Q_hold", dif.Q, 14);

      // 2: A<B, then back-to-back start in the done cycle
      start_op(32'd5, 32'd9);
      wait_done(lat, bcnt);
      chk("t2a_Q", dif.Q, 0);
      chk("t2a_R", dif.R, 5);
      start_op(32'hFFFF_FFFF, 32'd1);
      chk("t2_b2b_done", dif.done, 0);
      chk("t2_b2b_busy", dif.busy, 1);
      wait_done(lat, bcnt);
      chk("t2b_lat", lat + 1, 33);
      chk("t2b_Q", dif.Q, 32'hFFFF_FFFF);
      chk("t2b_R", dif.R, 0);

      // 3: divide by zero
      @(posedge clk);
      #1;
      start_op(32'h1234, 32'd0);
      wait_done(lat, bcnt);
      chk("t3_lat",  lat + 1, 1);
      chk("t3_busy", bcnt, 0);
      chk("t3_busy_done", dif.busy, 0);
      chk("t3_Q",   dif.Q, 32'hFFFF_FFFF);
      chk("t3_R",   dif.R, 32'h1234);
      chk("t3_dbz", dif.dbz, 1);
      @(posedge clk);
      #1;
      chk("t3_done_pulse", dif.done, 0);
      chk("t3_dbz_hold", dif.dbz, 1);
      start_op(32'd10, 32'd3);
      chk("t3_dbz_clr", dif.dbz, 0);
      wait_done(lat, bcnt);
      chk("t3b_Q", dif.Q, 3);
      chk("t3b_R", dif.R, 1);

      // 4: start mid-RUN is ignored
      @(posedge clk);
      #1;
      start_op(32'd1000, 32'd3);
      repeat (4) @(posedge clk);
      #1;
      dif.start = 1'b1;
      dif.A     = 32'd50;
      dif.B     = 32'd5;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      wait_done(lat, bcnt);
      chk("t4_lat", lat + 6, 33);
      chk("t4_Q", dif.Q, 333);
      chk("t4_R", dif.R, 1);
      @(posedge clk);
      #1;
      chk("t4_idle", dif.busy, 0);

      // 5: async reset mid-operation
      start_op(32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_busy", dif.busy, 0);
      chk("t5_done", dif.done, 0);
      chk("t5_Q",    dif.Q, 0);
      chk("t5_R",    dif.R, 0);
      chk("t5_dbz",  dif.dbz, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_idle", dif.busy, 0);
      start_op(32'd9, 32'd2);
      wait_done(lat, bcnt);
      chk("t5_lat", lat + 1, 33);
      chk("t5b_Q", dif.Q, 4);
      chk("t5b_R", dif.R, 1);

      // 6: signed cases, or the same bit patterns as unsigned
      @(posedge clk);
      #1;
`ifdef SIGNED_DIV_EN
      start_op(-32'sd7, 32'sd2);
      wait_done(lat, bcnt);
      chk("t6a_Q", dif.Q, 32'hFFFF_FFFD);
      chk("t6a_R", dif.R, 32'hFFFF_FFFF);
      chk("t6a_OF", dif.OF, 0);
      start_op(32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat, bcnt);
      chk("t6b_lat", lat + 1, 33);
      chk("t6b_Q", dif.Q, 32'h8000_0000);
      chk("t6b_R", dif.R, 0);
      chk("t6b_OF", dif.OF, 1);
      start_op(32'd20, 32'd6);
      chk("t6_OF_clr", dif.OF, 0);
      wait_done(lat, bcnt);
      chk("t6c_Q", dif.Q, 3);
      chk("t6c_R", dif.R, 2);
`else
      start_op(32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat, bcnt);
      chk("t6u_Q", dif.Q, 0);
      chk("t6u_R", dif.R, 32'h8000_0000);
      chk("t6u_OF", dif.OF, 0);
      start_op(32'hFFFF_FFF9, 32'd2);
      wait_done(lat, bcnt);
      chk("t6v_Q", dif.Q, 32'h7FFF_FFFC);
      chk("t6v_R", dif.R, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
